// File: rtl/viterbi_sym_piso_if.sv
// rtl/viterbi_sym_piso_if.sv - handshake and symbol stream bundle for the Viterbi symbol serializer
interface viterbi_sym_piso_if #(
    parameter int SIZE_DATA_IN = 16,
    parameter int SIZE_SYM     = 2
);
    logic                    i_start;
    logic [SIZE_DATA_IN-1:0] i_data;
    logic                    i_stall;
    logic                    o_ready;
    logic [SIZE_SYM-1:0]     o_sym;
    logic                    o_sym_valid;
    logic                    o_sym_last;
    logic                    o_busy;
    logic                    o_done;

    modport master (
        output i_start, i_data, i_stall,
        input  o_ready, o_sym, o_sym_valid, o_sym_last, o_busy, o_done
    );

    modport slave (
        input  i_start, i_data, i_stall,
        output o_ready, o_sym, o_sym_valid, o_sym_last, o_busy, o_done
    );
endinterface

// File: rtl/viterbi_sym_piso.sv
// rtl/viterbi_sym_piso.sv - serializes one coded word into MSB-first code symbols for the decoder
module viterbi_sym_piso #(
    parameter int SIZE_DATA_IN = 16,
    parameter int SIZE_SYM     = 2
) (
    input logic               i_clk,
    input logic               i_rst,
    viterbi_sym_piso_if.slave bus
);
    localparam int N     = SIZE_DATA_IN / SIZE_SYM;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [SIZE_DATA_IN-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // A stall freezes the whole datapath, so the last symbol can be held as long as any other.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    state_d = S_SHIFT;
                    shreg_d = bus.i_data;
                    cnt_d   = '0;
                end
            end
            S_SHIFT: begin
                if (!bus.i_stall) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        shreg_d = shreg_q << SIZE_SYM;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.o_ready     = (state_q == S_IDLE);
        bus.o_sym_valid = (state_q == S_SHIFT);
        bus.o_sym       = '0;
        bus.o_sym_last  = 1'b0;
        bus.o_busy      = (state_q == S_SHIFT) || (state_q == S_DONE);
        bus.o_done      = (state_q == S_DONE);
        if (state_q == S_SHIFT) begin
            bus.o_sym      = shreg_q[SIZE_DATA_IN-1 -: SIZE_SYM];
            bus.o_sym_last = (cnt_q == CNT_LAST);
        end
    end
endmodule

// File: tb/tb_viterbi_sym_piso.sv
// tb/tb_viterbi_sym_piso.sv - directed self-checking bench for viterbi_sym_piso
module tb_viterbi_sym_piso;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    int   cyc      = 0;

    viterbi_sym_piso_if #(.SIZE_DATA_IN(16), .SIZE_SYM(2)) bus ();

    viterbi_sym_piso #(.SIZE_DATA_IN(16), .SIZE_SYM(2)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.o_done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entered 1 time unit after the accepting edge; e holds the 8 expected symbols, first symbol leftmost.
    task automatic run_frame(input string tag, input logic [7:0][1:0] e,
                             input int sa, input int na, input int sb, input int nb,
                             output int lat);
        int hold;
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            hold = 1 + ((i == sa) ? na : 0) + ((i == sb) ? nb : 0);
            for (int k = 0; k < hold; k++) begin
                check($sformatf("%s_valid%0d", tag, i), 32'(bus.o_sym_valid), 32'd1);
                check($sformatf("%s_sym%0d", tag, i), 32'(bus.o_sym), 32'(e[7-i]));
                check($sformatf("%s_last%0d", tag, i), 32'(bus.o_sym_last), (i == 7) ? 32'd1 : 32'd0);
                check($sformatf("%s_nodone%0d", tag, i), 32'(bus.o_done), 32'd0);
                check($sformatf("%s_busy%0d", tag, i), 32'(bus.o_busy), 32'd1);
                check($sformatf("%s_nordy%0d", tag, i), 32'(bus.o_ready), 32'd0);
                bus.i_stall = (k < hold - 1);
                @(posedge clk); #1;
                lat++;
            end
        end
        bus.i_stall = 1'b0;
        check({tag, "_done"}, 32'(bus.o_done), 32'd1);
        check({tag, "_done_valid"}, 32'(bus.o_sym_valid), 32'd0);
        check({tag, "_done_sym"}, 32'(bus.o_sym), 32'd0);
        check({tag, "_done_busy"}, 32'(bus.o_busy), 32'd1);
        check({tag, "_done_rdy"}, 32'(bus.o_ready), 32'd0);
        @(posedge clk); #1;
        check({tag, "_idle_rdy"}, 32'(bus.o_ready), 32'd1);
        check({tag, "_idle_done"}, 32'(bus.o_done), 32'd0);
        check({tag, "_idle_busy"}, 32'(bus.o_busy), 32'd0);
    endtask

    task automatic start_frame(input logic [15:0] d);
        bus.i_start = 1'b1;
        bus.i_data  = d;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
    endtask

    localparam logic [7:0][1:0] SYM_A5A5 = {2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01};
    localparam logic [7:0][1:0] SYM_5A5A = {2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10};
    localparam logic [7:0][1:0] SYM_FFFF = {2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
    localparam logic [7:0][1:0] SYM_0000 = {2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [7:0][1:0] SYM_1234 = {2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 2'b01, 2'b00};

    initial begin
        int lat;
        int c0;
        int c1;
        int dones_before;
        logic [7:0][1:0] tbl;

        bus.i_start = 1'b0;
        bus.i_data  = '0;
        bus.i_stall = 1'b0;

        #3;
        check("rst_ready", 32'(bus.o_ready), 32'd1);
        check("rst_valid", 32'(bus.o_sym_valid), 32'd0);
        check("rst_sym", 32'(bus.o_sym), 32'd0);
        check("rst_last", 32'(bus.o_sym_last), 32'd0);
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        check("rst_done", 32'(bus.o_done), 32'd0);
        @(posedge clk); #4;
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_ready", 32'(bus.o_ready), 32'd1);
        check("idle_valid", 32'(bus.o_sym_valid), 32'd0);

        start_frame(16'hA5A5);
        run_frame("a5a5", SYM_A5A5, -1, 0, -1, 0, lat);
        check("a5a5_lat", 32'(lat), 32'd8);

        start_frame(16'hFFFF);
        run_frame("ffff", SYM_FFFF, -1, 0, -1, 0, lat);
        start_frame(16'h0000);
        run_frame("zero", SYM_0000, -1, 0, -1, 0, lat);

        start_frame(16'hA5A5);
        run_frame("stall", SYM_A5A5, 2, 3, 7, 2, lat);
        check("stall_lat", 32'(lat), 32'd13);

        // Start stays high with a different word through SHIFT and DONE.
        bus.i_start = 1'b1;
        bus.i_data  = 16'hA5A5;
        @(posedge clk); #1;
        bus.i_data = 16'h1234;
        run_frame("ign", SYM_A5A5, -1, 0, -1, 0, lat);
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        run_frame("h1234", SYM_1234, -1, 0, -1, 0, lat);

        start_frame(16'hA5A5);
        tbl = SYM_A5A5;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("pre_rst_sym%0d", i), 32'(bus.o_sym), 32'(tbl[7-i]));
            @(posedge clk); #1;
        end
        check("pre_rst_sym4", 32'(bus.o_sym), 32'b10);
        dones_before = done_cnt;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ready", 32'(bus.o_ready), 32'd1);
        check("mid_rst_valid", 32'(bus.o_sym_valid), 32'd0);
        check("mid_rst_sym", 32'(bus.o_sym), 32'd0);
        check("mid_rst_last", 32'(bus.o_sym_last), 32'd0);
        check("mid_rst_busy", 32'(bus.o_busy), 32'd0);
        check("mid_rst_done", 32'(bus.o_done), 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", 32'(bus.o_ready), 32'd1);
        check("post_rst_nodone", 32'(done_cnt - dones_before), 32'd0);
        start_frame(16'hFFFF);
        run_frame("ffff2", SYM_FFFF, -1, 0, -1, 0, lat);

        bus.i_start = 1'b1;
        bus.i_data  = 16'hA5A5;
        @(posedge clk); #1;
        c0 = cyc;
        bus.i_data = 16'h5A5A;
        run_frame("b2b_a", SYM_A5A5, -1, 0, -1, 0, lat);
        @(posedge clk); #1;
        c1 = cyc;
        bus.i_start = 1'b0;
        run_frame("b2b_b", SYM_5A5A, -1, 0, -1, 0, lat);
        check("b2b_spacing", 32'(c1 - c0), 32'd10);

        @(posedge clk); #1;
        check("done_total", 32'(done_cnt), 32'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
